// File: rtl/sound_mixer_matrix.sv
// Crosspoint sound mixer: CH_COUNT signed sources into OUT_COUNT saturated buses.
// A single multiplier walks every (output, channel) pair once per sample frame.
module sound_mixer_matrix #(
  parameter int CH_COUNT     = 4,
  parameter int OUT_COUNT    = 2,
  parameter int IN_WIDTH     = 16,
  parameter int OUT_WIDTH    = 16,
  parameter int GAIN_WIDTH   = 8,
  parameter int GAIN_FRAC    = 6,
  parameter int DEFAULT_GAIN = 64,
  localparam int CW = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1,
  localparam int OW = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1
) (
  input  logic                          RESET_n,
  input  logic                          CLK,
  input  logic                          SAMPLE_STB,
  input  logic [CH_COUNT*IN_WIDTH-1:0]  IN_SIGNAL,
  input  logic [CH_COUNT-1:0]           MUTE,
  input  logic                          GAIN_WE,
  input  logic [CW-1:0]                 GAIN_CH,
  input  logic [OW-1:0]                 GAIN_OUT,
  input  logic [GAIN_WIDTH-1:0]         GAIN_DATA,
  input  logic                          STATUS_CLR,
  output logic [OUT_COUNT*OUT_WIDTH-1:0] OUT_SIGNAL,
  output logic                          OUT_VALID,
  output logic                          BUSY,
  output logic [OUT_COUNT-1:0]          CLIP,
  output logic                          OVERRUN
);

  localparam int ACC_W = IN_WIDTH + GAIN_WIDTH + 1 + $clog2(CH_COUNT);
  localparam int PW    = IN_WIDTH + GAIN_WIDTH + 1;
  localparam logic signed [ACC_W-1:0] OMAX =
    {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OMIN = ~OMAX;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] c_q, c_d;
  logic [OW-1:0] o_q, o_d;
  logic signed [IN_WIDTH-1:0] snap_q [CH_COUNT];
  logic signed [IN_WIDTH-1:0] snap_d [CH_COUNT];
  logic [CH_COUNT-1:0] mute_q, mute_d;
  logic [GAIN_WIDTH-1:0] gain_q [OUT_COUNT][CH_COUNT];
  logic [GAIN_WIDTH-1:0] gain_d [OUT_COUNT][CH_COUNT];
  logic signed [ACC_W-1:0] acc_q [OUT_COUNT];
  logic signed [ACC_W-1:0] acc_d [OUT_COUNT];
  logic pend_q, pend_d;
  logic [CW-1:0] pend_c_q, pend_c_d;
  logic [OW-1:0] pend_o_q, pend_o_d;
  logic [GAIN_WIDTH-1:0] pend_g_q, pend_g_d;
  logic [OUT_COUNT*OUT_WIDTH-1:0] out_q, out_d;
  logic valid_q, valid_d;
  logic [OUT_COUNT-1:0] clip_q, clip_d;
  logic ovr_q, ovr_d;
  logic wr_ok;
  logic signed [PW-1:0] prod;
  logic signed [ACC_W-1:0] y;

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    o_d      = o_q;
    snap_d   = snap_q;
    mute_d   = mute_q;
    gain_d   = gain_q;
    acc_d    = acc_q;
    pend_d   = pend_q;
    pend_c_d = pend_c_q;
    pend_o_d = pend_o_q;
    pend_g_d = pend_g_q;
    out_d    = out_q;
    valid_d  = 1'b0;
    prod     = '0;
    y        = '0;
    clip_d   = STATUS_CLR ? '0 : clip_q;
    ovr_d    = STATUS_CLR ? 1'b0 : ovr_q;
    wr_ok    = GAIN_WE && (int'(GAIN_CH) < CH_COUNT)
               && (int'(GAIN_OUT) < OUT_COUNT);
    if (SAMPLE_STB && state_q != IDLE) ovr_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          gain_d[pend_o_q][pend_c_q] = pend_g_q;
          pend_d = wr_ok;
        end else if (wr_ok) begin
          gain_d[GAIN_OUT][GAIN_CH] = GAIN_DATA;
        end
        if (SAMPLE_STB) begin
          for (int c = 0; c < CH_COUNT; c++)
            snap_d[c] = IN_SIGNAL[c*IN_WIDTH +: IN_WIDTH];
          for (int o = 0; o < OUT_COUNT; o++) acc_d[o] = '0;
          mute_d  = MUTE;
          c_d     = '0;
          o_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (wr_ok) pend_d = 1'b1;
        if (!mute_q[c_q])
          prod = PW'(snap_q[c_q])
               * PW'($signed({1'b0, gain_q[o_q][c_q]}));
        acc_d[o_q] = acc_q[o_q] + ACC_W'(prod);
        if (c_q == CW'(CH_COUNT-1)) begin
          c_d = '0;
          if (o_q == OW'(OUT_COUNT-1)) state_d = DONE;
          else o_d = o_q + 1'b1;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      DONE: begin
        if (pend_q) begin
          gain_d[pend_o_q][pend_c_q] = pend_g_q;
          pend_d = wr_ok;
        end else if (wr_ok) begin
          pend_d = 1'b1;
        end
        for (int o = 0; o < OUT_COUNT; o++) begin
          y = acc_q[o] >>> GAIN_FRAC;
          if (y > OMAX) begin
            y = OMAX;
            clip_d[o] = 1'b1;
          end else if (y < OMIN) begin
            y = OMIN;
            clip_d[o] = 1'b1;
          end
          out_d[o*OUT_WIDTH +: OUT_WIDTH] = y[OUT_WIDTH-1:0];
        end
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // a write that arrives while busy (or queued behind one) parks here
    if (wr_ok && (state_q != IDLE || pend_q)) begin
      pend_c_d = GAIN_CH;
      pend_o_d = GAIN_OUT;
      pend_g_d = GAIN_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q  <= IDLE;
      c_q      <= '0;
      o_q      <= '0;
      mute_q   <= '0;
      pend_q   <= 1'b0;
      pend_c_q <= '0;
      pend_o_q <= '0;
      pend_g_q <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      clip_q   <= '0;
      ovr_q    <= 1'b0;
      for (int c = 0; c < CH_COUNT; c++) snap_q[c] <= '0;
      for (int o = 0; o < OUT_COUNT; o++) begin
        acc_q[o] <= '0;
        for (int c = 0; c < CH_COUNT; c++)
          gain_q[o][c] <= GAIN_WIDTH'(DEFAULT_GAIN);
      end
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      o_q      <= o_d;
      snap_q   <= snap_d;
      mute_q   <= mute_d;
      gain_q   <= gain_d;
      acc_q    <= acc_d;
      pend_q   <= pend_d;
      pend_c_q <= pend_c_d;
      pend_o_q <= pend_o_d;
      pend_g_q <= pend_g_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      clip_q   <= clip_d;
      ovr_q    <= ovr_d;
    end
  end

  assign OUT_SIGNAL = out_q;
  assign OUT_VALID  = valid_q;
  assign BUSY       = (state_q != IDLE);
  assign CLIP       = clip_q;
  assign OVERRUN    = ovr_q;

endmodule

// File: tb/tb_sound_mixer_matrix.sv
// Directed bench for sound_mixer_matrix with a sum-of-products mix model.
// A negedge compare process checks every OUT_VALID against queued expectations.
module tb_sound_mixer_matrix;

  logic        RESET_n = 1'b0;
  logic        CLK = 1'b0;
  logic        SAMPLE_STB = 1'b0;
  logic [63:0] IN_SIGNAL = '0;
  logic [3:0]  MUTE = '0;
  logic        GAIN_WE = 1'b0;
  logic [1:0]  GAIN_CH = '0;
  logic [0:0]  GAIN_OUT = '0;
  logic [7:0]  GAIN_DATA = '0;
  logic        STATUS_CLR = 1'b0;
  logic [31:0] OUT_SIGNAL;
  logic        OUT_VALID;
  logic        BUSY;
  logic [1:0]  CLIP;
  logic        OVERRUN;

  sound_mixer_matrix dut (
    .RESET_n(RESET_n), .CLK(CLK), .SAMPLE_STB(SAMPLE_STB),
    .IN_SIGNAL(IN_SIGNAL), .MUTE(MUTE), .GAIN_WE(GAIN_WE),
    .GAIN_CH(GAIN_CH), .GAIN_OUT(GAIN_OUT), .GAIN_DATA(GAIN_DATA),
    .STATUS_CLR(STATUS_CLR), .OUT_SIGNAL(OUT_SIGNAL),
    .OUT_VALID(OUT_VALID), .BUSY(BUSY), .CLIP(CLIP),
    .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int o0;
    int o1;
    logic [1:0] clip;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int in_v[4];
  logic [3:0] mute_v;
  int mg[2][4];
  logic [1:0] clip_exp = '0;

  task automatic chk(input string n, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, got, want);
    end
  endtask

  function automatic int o_at(input int o);
    return int'($signed(OUT_SIGNAL[o*16 +: 16]));
  endfunction

  function automatic longint raw_mix(input int o);
    longint s = 0;
    for (int c = 0; c < 4; c++)
      if (!mute_v[c]) s += longint'(in_v[c]) * mg[o][c];
    return s >>> 6;
  endfunction

  function automatic int clampv(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic exp_t model();
    exp_t e;
    longint r0 = raw_mix(0);
    longint r1 = raw_mix(1);
    e.o0 = clampv(r0);
    e.o1 = clampv(r1);
    e.clip = {(r1 != longint'(e.o1)), (r0 != longint'(e.o0))};
    return e;
  endfunction

  always @(negedge CLK) begin
    exp_t e;
    if (RESET_n && OUT_VALID) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid: got OUT_VALID=1 expected 0");
      end else begin
        e = q.pop_front();
        clip_exp = clip_exp | e.clip;
        chk("out0", o_at(0), e.o0);
        chk("out1", o_at(1), e.o1);
        chk("clip", int'(CLIP), int'(clip_exp));
      end
    end
  end

  task automatic set_in(input int a, input int b, input int c,
                        input int d, input logic [3:0] m);
    in_v = '{a, b, c, d};
    mute_v = m;
    for (int i = 0; i < 4; i++) IN_SIGNAL[i*16 +: 16] = 16'(in_v[i]);
    MUTE = m;
  endtask

  task automatic gwrite(input int o, input int c, input int v);
    GAIN_OUT = 1'(o);
    GAIN_CH = 2'(c);
    GAIN_DATA = 8'(v);
    GAIN_WE = 1'b1;
    @(posedge CLK); #1;
    GAIN_WE = 1'b0;
    mg[o][c] = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic status_clr();
    STATUS_CLR = 1'b1;
    @(posedge CLK); #1;
    STATUS_CLR = 1'b0;
    clip_exp = '0;
  endtask

  task automatic run_frame(input bit ovr, input bit wr);
    int cyc = 0;
    int busy = 0;
    bit got = 0;
    q.push_back(model());
    SAMPLE_STB = 1'b1;
    @(posedge CLK); #1;
    SAMPLE_STB = 1'b0;
    while (!got && cyc < 40) begin
      if (BUSY) busy++;
      if (OUT_VALID) got = 1;
      else begin
        SAMPLE_STB = ovr && cyc == 2;
        if (wr && cyc == 3) begin
          GAIN_OUT = 1'b1;
          GAIN_CH = 2'd0;
          GAIN_DATA = 8'd0;
          GAIN_WE = 1'b1;
        end
        @(posedge CLK); #1;
        SAMPLE_STB = 1'b0;
        GAIN_WE = 1'b0;
        cyc++;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got no OUT_VALID expected one");
    end
    chk("valid_latency", cyc, 9);
    chk("busy_cycles", busy, 9);
    @(posedge CLK); #1;
    chk("valid_pulse", int'(OUT_VALID), 0);
    idle(14);
  endtask

  initial begin
    for (int o = 0; o < 2; o++)
      for (int c = 0; c < 4; c++) mg[o][c] = 64;
    set_in(0, 0, 0, 0, 4'b0000);
    #12;
    chk("rst_out", int'(OUT_SIGNAL), 0);
    chk("rst_valid", int'(OUT_VALID), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_clip", int'(CLIP), 0);
    chk("rst_ovr", int'(OVERRUN), 0);
    RESET_n = 1'b1;
    idle(2);

    set_in(1000, 2000, -500, 0, 4'b0000);
    run_frame(0, 0);
    chk("t1_out0", o_at(0), 2500);
    chk("t1_out1", o_at(1), 2500);

    gwrite(0, 1, 32);
    run_frame(0, 0);
    chk("t2_out0", o_at(0), 1500);
    chk("t2_out1", o_at(1), 2500);
    chk("t2_hold", o_at(0), 1500);

    for (int o = 0; o < 2; o++)
      for (int c = 0; c < 4; c++) gwrite(o, c, 255);
    set_in(32767, 32767, 32767, 32767, 4'b0000);
    run_frame(0, 0);
    chk("t3_out0", o_at(0), 32767);
    chk("t3_clip", int'(CLIP), 3);
    set_in(-32768, -32768, -32768, -32768, 4'b0000);
    run_frame(0, 0);
    chk("t3_out1", o_at(1), -32768);
    status_clr();
    chk("t3_clr", int'(CLIP), 0);

    for (int o = 0; o < 2; o++)
      for (int c = 0; c < 4; c++) gwrite(o, c, 64);
    set_in(1000, 2000, -500, 0, 4'b0100);
    run_frame(0, 0);
    chk("t4_out0", o_at(0), 3000);
    chk("t4_out1", o_at(1), 3000);

    set_in(1000, 2000, -500, 0, 4'b0000);
    run_frame(1, 1);
    chk("t5_ovr", int'(OVERRUN), 1);
    chk("t5_out1", o_at(1), 2500);
    mg[1][0] = 0;
    run_frame(0, 0);
    chk("t5_next1", o_at(1), 1500);
    chk("t5_next0", o_at(0), 2500);

    SAMPLE_STB = 1'b1;
    @(posedge CLK); #1;
    SAMPLE_STB = 1'b0;
    idle(4);
    RESET_n = 1'b0;
    #2;
    chk("t6_out", int'(OUT_SIGNAL), 0);
    chk("t6_busy", int'(BUSY), 0);
    chk("t6_ovr", int'(OVERRUN), 0);
    idle(2);
    RESET_n = 1'b1;
    for (int o = 0; o < 2; o++)
      for (int c = 0; c < 4; c++) mg[o][c] = 64;
    clip_exp = '0;
    idle(15);
    run_frame(0, 0);
    chk("t6_out0", o_at(0), 2500);
    chk("t6_out1", o_at(1), 2500);
    chk("q_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sound_mixer_matrix.md
Name: sound_mixer_matrix

Overview:
- Parametrised successor to the fixed attenuator+mixer chains.
- Mixes CH_COUNT signed sound sources into OUT_COUNT output buses (e.g. external, cartridge-internal).
- Each (output, channel) crosspoint has a runtime-programmable gain and each channel has a mute.
- One shared multiplier is time-multiplexed per sample frame; outputs are saturated, with sticky clip/overrun status.

Parameters:
CH_COUNT, 4, number of input channels (>=1)
OUT_COUNT, 2, number of output buses (>=1)
IN_WIDTH, 16, signed input sample width
OUT_WIDTH, 16, signed output sample width
GAIN_WIDTH, 8, unsigned gain width
GAIN_FRAC, 6, gain fractional bits (unity = 2^GAIN_FRAC = 64)
DEFAULT_GAIN, 64, gain loaded into every crosspoint at reset

Ports:
RESET_n  in  1  asynchronous active-low reset
CLK  in  1  system clock
SAMPLE_STB  in  1  one-cycle pulse: start a mix frame
IN_SIGNAL  in  CH_COUNT*IN_WIDTH  packed signed inputs, channel c at [c*IN_WIDTH +: IN_WIDTH]
MUTE  in  CH_COUNT  per-channel mute, sampled with inputs
GAIN_WE  in  1  gain write strobe
GAIN_CH  in  max(1,$clog2(CH_COUNT))  gain write channel index
GAIN_OUT  in  max(1,$clog2(OUT_COUNT))  gain write output index
GAIN_DATA  in  GAIN_WIDTH  gain value
STATUS_CLR  in  1  clears CLIP and OVERRUN
OUT_SIGNAL  out  OUT_COUNT*OUT_WIDTH  packed signed mixed outputs
OUT_VALID  out  1  one-cycle pulse: OUT_SIGNAL updated
BUSY  out  1  frame in progress
CLIP  out  OUT_COUNT  sticky saturation flag per output
OVERRUN  out  1  sticky: SAMPLE_STB arrived while BUSY

Behaviour:
- Reset (async): OUT_SIGNAL=0, OUT_VALID=0, BUSY=0, CLIP=0, OVERRUN=0, state=IDLE, every gain=DEFAULT_GAIN, pending-write empty. Reset mid-frame aborts the frame; no OUT_VALID is produced.
- States: IDLE, RUN, DONE. N = CH_COUNT*OUT_COUNT.
- IDLE + SAMPLE_STB (edge t):
  - snapshot IN_SIGNAL and MUTE;
  - clear all accumulators;
  - step counter k=0; state=RUN; BUSY=1.
- RUN, edges t+1..t+N: step k uses c = k mod CH_COUNT, o = k / CH_COUNT.
  - acc[o] += snap[c] * gain[o][c]; signed input times zero-extended gain.
  - Muted channels add 0.
  - After k=N-1, state=DONE.
- DONE, edge t+N+1:
  - for each o: y = acc[o] >>> GAIN_FRAC (arithmetic, truncation toward -inf);
  - saturate y to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1];
  - register into OUT_SIGNAL;
  - OUT_VALID=1 for exactly one cycle;
  - BUSY=0; state=IDLE.
- Latency: OUT_VALID high in cycle t+N+2, counting the strobe cycle as t.
- Accumulator width: IN_WIDTH+GAIN_WIDTH+1+$clog2(CH_COUNT). The accumulator never wraps.
- OUT_SIGNAL holds its value between frames.
- Saturation sets CLIP[o]; CLIP stays set until STATUS_CLR.
- SAMPLE_STB while BUSY, including the DONE cycle: ignored and OVERRUN set. The frame in progress is unaffected.
- STATUS_CLR coincident with a new clip/overrun event: the set wins.
- Gain writes:
  - In IDLE with no pending write: applied at the next edge.
  - While BUSY: stored in a single pending register, overwritten by later writes. Applied on the edge leaving DONE, so the current frame uses the old gains.
  - GAIN_WE in the DONE cycle: becomes pending, applied one cycle later.
  - SAMPLE_STB in the IDLE cycle where a pending write is applied: the new frame uses the updated gain.
- Out-of-range GAIN_CH/GAIN_OUT: write ignored.

Test Plan:
1. Default gains 64, inputs {1000,2000,-500,0}, strobe -> BUSY for 9 cycles; OUT_VALID single pulse at t+10; both outputs 2500.
2. Write gain[0][1]=32 in IDLE, same inputs -> out0=1500, out1=2500.
3. All inputs 32767, all gains 255 -> outputs 32767, CLIP=2'b11. All inputs -32768 -> outputs -32768. STATUS_CLR -> CLIP=0.
4. MUTE=4'b0100 with test-1 inputs -> both outputs 3000.
5. Strobe at t+3 of a frame -> OVERRUN=1 and only one OUT_VALID. Gain write gain[1][0]=0 at t+4 -> this frame out1=2500, next frame out1=1500.
6. RESET_n low at t+5 of a frame -> no OUT_VALID; OUT_SIGNAL=0. The next frame with test-1 inputs yields 2500/2500, showing gains were reset to 64.
